// File: rtl/ctrl_seq_fsm.sv
// ctrl_seq_fsm: multi-cycle instruction sequencer.
// Accepts one instruction in FETCH, decodes it, then runs a single-cycle
// EXEC, a multi-cycle rotate (MOVR/MOVRHS) or a pause, and ends in DONE.
// All control outputs are Moore-decoded from state, latched fields and counters.
// The only exception is the BRZ branch decision, which looks at reg0_is_zero during EXEC.
// Build option: define CTRL_SEQ_ILLEGAL_TRAP_EN to send illegal opcodes to a
// sticky TRAP state. Without it, illegal opcodes retire as a NOP.
module ctrl_seq_fsm #(
    parameter int ROT_W   = 4,
    parameter int DELAY_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [3:0]         opcode,
    input  logic [ROT_W-1:0]   rot_count,
    input  logic [DELAY_W-1:0] pause_cycles,
    input  logic               reg0_is_zero,
    output logic               write_reg_file,
    output logic               result_mux_select,
    output logic [1:0]         op1_sel,
    output logic [1:0]         op2_sel,
    output logic [1:0]         imm_sel,
    output logic [1:0]         write_addr_sel,
    output logic [1:0]         alu_op,
    output logic               rot_dir,
    output logic               commit_branch,
    output logic               increment_pc,
    output logic               busy,
    output logic               illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ROT, S_PAUSE, S_DONE, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_BR     = 4'd0,
        OP_BRZ    = 4'd1,
        OP_ADDI   = 4'd2,
        OP_SUBI   = 4'd3,
        OP_SR0    = 4'd4,
        OP_SRH0   = 4'd5,
        OP_CLR    = 4'd6,
        OP_MOV    = 4'd7,
        OP_MOVR   = 4'd8,
        OP_MOVRHS = 4'd9,
        OP_PAUSE  = 4'd10
    } opcode_t;

    state_t             state_q;
    logic [3:0]         opcode_q;
    logic [ROT_W-1:0]   rot_count_q;
    logic [DELAY_W-1:0] pause_q;
    logic [ROT_W-1:0]   rot_cnt_q;
    logic [DELAY_W-1:0] delay_cnt_q;
    logic               rot_dir_q;
    logic [ROT_W-1:0]   rot_mag_d;

    // Magnitude of the signed rotate count. The most negative value maps to
    // 2^(ROT_W-1), which still fits in the unsigned ROT_W-bit counter.
    assign rot_mag_d = rot_count_q[ROT_W-1] ? (~rot_count_q + 1'b1) : rot_count_q;

    // State register, field latches and down-counters.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the reset is synchronous. Every register is cleared
            // here because there is no storage array that could skip reset.
            state_q     <= S_FETCH;
            opcode_q    <= '0;
            rot_count_q <= '0;
            pause_q     <= '0;
            rot_cnt_q   <= '0;
            delay_cnt_q <= '0;
            rot_dir_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        opcode_q    <= opcode;
                        rot_count_q <= rot_count;
                        pause_q     <= pause_cycles;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode_q)
                        OP_BR, OP_BRZ, OP_ADDI, OP_SUBI,
                        OP_SR0, OP_SRH0, OP_CLR, OP_MOV: state_q <= S_EXEC;
                        OP_MOVR, OP_MOVRHS: begin
                            rot_cnt_q <= rot_mag_d;
                            rot_dir_q <= ~rot_count_q[ROT_W-1];
                            state_q   <= (rot_mag_d != '0) ? S_ROT : S_DONE;
                        end
                        OP_PAUSE: begin
                            delay_cnt_q <= pause_q;
                            state_q     <= (pause_q != '0) ? S_PAUSE : S_DONE;
                        end
                        default: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                            state_q <= S_TRAP;
`else
                            state_q <= S_DONE;
`endif
                        end
                    endcase
                end
                S_EXEC: state_q <= S_FETCH;
                S_ROT: begin
                    rot_cnt_q <= rot_cnt_q - 1'b1;
                    if (rot_cnt_q == ROT_W'(1)) state_q <= S_DONE;
                end
                S_PAUSE: begin
                    delay_cnt_q <= delay_cnt_q - 1'b1;
                    if (delay_cnt_q == DELAY_W'(1)) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode. Everything is forced low while reset is high.
    always_comb begin
        // NOTE: each output gets a default first, so no path can infer a latch.
        instr_ready       = 1'b0;
        write_reg_file    = 1'b0;
        result_mux_select = 1'b0;
        op1_sel           = 2'b00;
        op2_sel           = 2'b00;
        imm_sel           = 2'b00;
        write_addr_sel    = 2'b00;
        alu_op            = 2'b00;
        rot_dir           = 1'b0;
        commit_branch     = 1'b0;
        increment_pc      = 1'b0;
        busy              = 1'b0;
        illegal_op        = 1'b0;
        if (!reset) begin
            busy = (state_q != S_FETCH);
            case (state_q)
                S_FETCH: instr_ready = 1'b1;
                S_EXEC: begin
                    case (opcode_q)
                        OP_BR, OP_BRZ: begin
                            if (opcode_q == OP_BR || reg0_is_zero) begin
                                imm_sel       = 2'b10;
                                op2_sel       = 2'b01;
                                alu_op        = 2'b01;
                                commit_branch = 1'b1;
                            end else begin
                                increment_pc  = 1'b1;
                            end
                        end
                        OP_ADDI, OP_SUBI: begin
                            imm_sel        = 2'b00;
                            op1_sel        = 2'b01;
                            op2_sel        = 2'b01;
                            alu_op         = (opcode_q == OP_ADDI) ? 2'b01 : 2'b00;
                            write_addr_sel = 2'b01;
                            write_reg_file = 1'b1;
                            increment_pc   = 1'b1;
                        end
                        OP_SR0, OP_SRH0: begin
                            imm_sel        = 2'b01;
                            op1_sel        = 2'b11;
                            op2_sel        = 2'b01;
                            alu_op         = (opcode_q == OP_SR0) ? 2'b10 : 2'b11;
                            write_addr_sel = 2'b00;
                            write_reg_file = 1'b1;
                            increment_pc   = 1'b1;
                        end
                        OP_CLR: begin
                            result_mux_select = 1'b1;
                            write_addr_sel    = 2'b01;
                            write_reg_file    = 1'b1;
                            increment_pc      = 1'b1;
                        end
                        OP_MOV: begin
                            imm_sel        = 2'b11;
                            op1_sel        = 2'b01;
                            op2_sel        = 2'b01;
                            write_addr_sel = 2'b10;
                            write_reg_file = 1'b1;
                            increment_pc   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_ROT: begin
                    write_reg_file = 1'b1;
                    op1_sel        = 2'b01;
                    op2_sel        = (opcode_q == OP_MOVR) ? 2'b11 : 2'b10;
                    write_addr_sel = 2'b01;
                    alu_op         = rot_dir_q ? 2'b00 : 2'b01;
                    rot_dir        = rot_dir_q;
                end
                S_DONE: increment_pc = 1'b1;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                S_TRAP: illegal_op = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ctrl_seq_fsm.md
CTRL_SEQ_FSM -- requirements
Module: ctrl_seq_fsm

Interface
REQ-001 SHALL have parameter ROT_W, default 4: width of signed rotate-count field.
REQ-002 SHALL have parameter DELAY_W, default 24: width of pause-cycle field and internal delay counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port instr_valid  in  1  instruction fields valid.
REQ-006 SHALL have port instr_ready  out  1  block accepts instruction.
REQ-007 SHALL have port opcode  in  4  0 BR, 1 BRZ, 2 ADDI, 3 SUBI, 4 SR0, 5 SRH0, 6 CLR, 7 MOV, 8 MOVR, 9 MOVRHS, 10 PAUSE, 11-15 illegal.
REQ-008 SHALL have port rot_count  in  ROT_W  signed rotate amount; positive = right, negative = left.
REQ-009 SHALL have port pause_cycles  in  DELAY_W  unsigned pause length in clk cycles.
REQ-010 SHALL have port reg0_is_zero  in  1  register 0 equals zero.
REQ-011 SHALL have outputs write_reg_file 1, result_mux_select 1, op1_sel 2, op2_sel 2, imm_sel 2, write_addr_sel 2, alu_op 2 (00 sub, 01 add, 10 set-low, 11 set-high), rot_dir 1 (1 = right), commit_branch 1, increment_pc 1, busy 1, illegal_op 1.

Function
REQ-012 States SHALL be FETCH, DECODE, EXEC, ROT, PAUSE, DONE, TRAP; all outputs SHALL be decoded combinationally from state, latched fields and counters (Moore); only write_reg_file, commit_branch and increment_pc pulse.
REQ-013 FETCH: instr_ready=1; on instr_valid&&instr_ready, opcode, rot_count and pause_cycles SHALL be latched and state SHALL become DECODE; otherwise remain FETCH.
REQ-014 DECODE (one cycle, no pulses): opcodes 0-7 -> EXEC; 8/9 -> ROT if |rot_count|!=0 else DONE; 10 -> PAUSE if pause_cycles!=0 else DONE; 11-15 per REQ-027/028.
REQ-015 EXEC (one cycle) -> FETCH: BR: imm_sel=10, op2_sel=01, alu_op=01, commit_branch=1. BRZ: same branch controls when reg0_is_zero=1 sampled in EXEC, else increment_pc=1 only.
REQ-016 EXEC ADDI/SUBI: imm_sel=00, op1_sel=01, op2_sel=01, alu_op=01/00, write_addr_sel=01, write_reg_file=1, increment_pc=1.
REQ-017 EXEC SR0/SRH0: imm_sel=01, op1_sel=11, op2_sel=01, alu_op=10/11, write_addr_sel=00, write_reg_file=1, increment_pc=1.
REQ-018 EXEC CLR: result_mux_select=1, write_addr_sel=01, write_reg_file=1, increment_pc=1; MOV: imm_sel=11, op1_sel=01, op2_sel=01, write_addr_sel=10, write_reg_file=1, increment_pc=1.
REQ-019 ROT: internal unsigned ROT_W-bit counter loaded in DECODE with |rot_count|; rot_count=-2^(ROT_W-1) SHALL load magnitude 2^(ROT_W-1) without overflow; rot_dir = sign inverse latched.
REQ-020 Each ROT cycle: write_reg_file=1, op1_sel=01, op2_sel=11 (MOVR) or 10 (MOVRHS), write_addr_sel=01, alu_op=00 if right else 01; counter decrements; on cycle where counter==1 -> DONE. Exactly |rot_count| write pulses.
REQ-021 PAUSE: internal DELAY_W counter loaded with pause_cycles in DECODE, decremented each PAUSE cycle; exit to DONE on cycle counter==1; PAUSE occupies exactly pause_cycles cycles.
REQ-022 DONE (one cycle): increment_pc=1 -> FETCH.
REQ-023 busy SHALL be 1 in every state except FETCH.
REQ-024 Latencies (FETCH acceptance to next FETCH): single-cycle ops 3 cycles; MOVR/MOVRHS N -> N+3 (N=0 -> 3); PAUSE P -> P+3 (P=0 -> 3).
REQ-025 Inputs other than reg0_is_zero SHALL be ignored outside the FETCH handshake cycle.

Reset
REQ-026 While reset=1 at a rising edge: state <= FETCH, counters and latched fields <= 0, illegal_op <= 0; all outputs including instr_ready SHALL be 0 while reset is high, in any state (mid-ROT/PAUSE aborts with no further pulses).

Configuration
REQ-027 With CTRL_SEQ_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; TRAP holds, illegal_op=1, busy=1, instr_ready=0, no pulses, until reset.
REQ-028 Without CTRL_SEQ_ILLEGAL_TRAP_EN: illegal opcode -> DONE (treated as NOP, one increment_pc pulse); illegal_op SHALL be tied 0.

Verification
REQ-029 Reset asserted 2 cycles mid-ROT with rot_count=5 -> outputs 0 during reset, FETCH with instr_ready=1 the cycle after release, no extra write pulse.
REQ-030 ADDI accepted -> DECODE, then EXEC with write_reg_file=1, alu_op=01, increment_pc=1, instr_ready=1 3 cycles after acceptance.
REQ-031 BRZ with reg0_is_zero=0 -> increment_pc=1, commit_branch=0; with reg0_is_zero=1 -> commit_branch=1, increment_pc=0.
REQ-032 MOVR rot_count=-8 (ROT_W=4) -> 8 write pulses, rot_dir=0, alu_op=01; rot_count=0 -> zero writes, DONE after DECODE.
REQ-033 PAUSE pause_cycles=1000 -> busy high 1002 cycles, single increment_pc on final busy cycle; pause_cycles=0 -> 3-cycle latency.
REQ-034 Opcode 13 -> TRAP with illegal_op=1 held 100 cycles (macro defined); NOP with one increment_pc pulse (macro undefined).
